// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiters.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_A = 2'd1,
    BUSY_B = 2'd2
  } arb_state_e;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_last_served,
  output logic o_gnt_vld,
  output logic o_owner
);

  // Single requester wins outright; a tie goes to whoever did not go last.
  always_comb begin
    o_gnt_vld = i_req_a | i_req_b;
    o_owner   = OWNER_A;
    if (i_req_a && i_req_b) o_owner = ~i_last_served;
    else if (i_req_b)       o_owner = OWNER_B;
  end

endmodule

// File: rtl/mem_port_arbiter2.sv
// Round-robin owner of a single memory port shared by fetch (A) and LSU (B).
// The grant is held until mem_ack or until the watchdog aborts the access.
module mem_port_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          we_a,
  output logic          ack_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  input  logic          we_b,
  output logic          ack_b,
  output logic [DW-1:0] rdata_b,
  output logic          err,
  output logic          sel,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_e    r_state, w_state_nxt;
  logic          r_last, w_last_nxt;
  logic          r_sel, w_sel_nxt;
  logic [CW-1:0] r_wd_cnt, w_wd_cnt_nxt;

  logic w_busy, w_owner, w_expire, w_done;
  logic w_gnt_vld, w_gnt_owner;
  logic w_other_req;

  rr_pick2 u_pick (
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .i_last_served(r_last),
    .o_gnt_vld    (w_gnt_vld),
    .o_owner      (w_gnt_owner)
  );

  assign w_busy      = (r_state != IDLE);
  assign w_owner     = (r_state == BUSY_B) ? OWNER_B : OWNER_A;
  assign w_other_req = (w_owner == OWNER_A) ? req_b : req_a;
  assign w_expire    = (r_wd_cnt == CW'(TIMEOUT - 1)) && !mem_ack;
  // A reset cycle kills the in-flight access silently: no ack, no err.
  assign w_done      = w_busy && (mem_ack || w_expire) && !rst;

  // Completion strobes; aborted accesses return zero data.
  always_comb begin
    ack_a   = w_done && (w_owner == OWNER_A);
    ack_b   = w_done && (w_owner == OWNER_B);
    err     = w_done && !mem_ack;
    rdata_a = (ack_a && mem_ack) ? mem_rdata : '0;
    rdata_b = (ack_b && mem_ack) ? mem_rdata : '0;
  end

  // Port steering follows the registered owner; held at zero while idle.
  always_comb begin
    sel       = r_sel;
    mem_req   = w_busy;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (w_busy) begin
      mem_addr  = r_sel ? addr_b  : addr_a;
      mem_wdata = r_sel ? wdata_b : wdata_a;
      mem_we    = r_sel ? we_b    : we_a;
    end
  end

  // Next-state: grant from idle, hand off directly on completion, count watchdog.
  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last;
    w_sel_nxt    = r_sel;
    w_wd_cnt_nxt = '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_sel_nxt   = w_gnt_owner;
          w_state_nxt = (w_gnt_owner == OWNER_B) ? BUSY_B : BUSY_A;
        end
      end
      BUSY_A, BUSY_B: begin
        if (w_done) begin
          w_last_nxt = w_owner;
          // The finishing requester's req still belongs to this access,
          // so only the other side is considered for the next grant.
          if (w_other_req) begin
            w_sel_nxt   = ~w_owner;
            w_state_nxt = (w_owner == OWNER_A) ? BUSY_B : BUSY_A;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_wd_cnt_nxt = r_wd_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State registers with synchronous reset; B marked last so A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last   <= OWNER_B;
      r_sel    <= OWNER_A;
      r_wd_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_sel    <= w_sel_nxt;
      r_wd_cnt <= w_wd_cnt_nxt;
    end
  end

endmodule
